execute_pipe: RTL and testbench
===============================

# execute_pipe

Parametrised multi-cycle execute unit with an internal register file, a valid/ready issue handshake, and an iterative unsigned divider. It accepts one instruction at a time, reads its operands from the register file, computes the result, writes it back, and reports completion with a one-cycle `out_valid` strobe plus status flags. It sits after the decode stage of the first CPU datapath and replaces the fixed 8-bit/4-register execute block.

## Interface
- `DATA_W`, 8: datapath and register width; must be ≥ 2.
- `REG_N`, 4: number of registers; a power of two, ≥ 2. `ADDR_W = $clog2(REG_N)` is a derived localparam.
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `in_valid` in 1: an instruction is presented.
- `in_ready` out 1: the unit can accept an instruction.
- `op_code` in 3: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 REM, 101 AND, 110 XOR, 111 LDI.
- `src_addr1`, `src_addr2` in ADDR_W: operand register indices.
- `dest_addr` in ADDR_W: write-back register index.
- `imm` in DATA_W: immediate value, used only by LDI.
- `result` out DATA_W: last completed result.
- `out_valid` out 1: one-cycle completion strobe.
- `flag_zero` out 1: `result == 0`.
- `flag_carry` out 1: ADD carry-out, SUB borrow, or MUL upper half nonzero; 0 for all other ops.
- `flag_dz` out 1: DIV or REM issued with a zero divisor.
- `rd_addr` in ADDR_W: debug read index.
- `rd_data` out DATA_W: combinational `reg_file[rd_addr]`.

## Operation
- **States:** IDLE, ALU, DIV, DONE.
- **Acceptance:** `in_ready` = 1 in IDLE and DONE, and 0 in ALU, DIV, and whenever `reset` = 1. An instruction is accepted on an edge where `in_valid & in_ready`.
- **Operand capture:** at acceptance, latch `a = reg_file[src_addr1]`, `b = reg_file[src_addr2]`, plus `op_code`, `dest_addr`, and `imm`.
- **Routing:** DIV or REM with `b ≠ 0` goes to DIV. Everything else, including DIV/REM with `b = 0`, goes to ALU.
- **ALU state (one cycle):**
  - ADD: `{c, r} = a + b`.
  - SUB: `r = a - b` (mod 2^DATA_W); `c = (a < b)`.
  - MUL: `r` = low DATA_W bits of `a*b`; `c` = high half nonzero.
  - AND, XOR: bitwise on `a`, `b`.
  - LDI: `r = imm`.
  - Divide by zero: DIV gives `r` = all ones; REM gives `r = a`; `flag_dz` = 1.
- **DIV state:** unsigned restoring division, one quotient bit per cycle, exactly DATA_W cycles. DIV returns the quotient; REM returns the remainder.
- **Completion edge (leaving ALU or DIV):**
  - `reg_file[dest_addr] <= r`.
  - `result`, `flag_zero`, `flag_carry`, and `flag_dz` update.
  - The state moves to DONE.
- **DONE state:** `out_valid` = 1 for this single cycle; then return to IDLE, or go to ALU/DIV if a new instruction is accepted in DONE.
- **Hold:** `result` and the flags hold their values until the next completion.
- **Hazards:** none. Write-back happens before any later instruction is accepted, so an instruction accepted in DONE reads the newly written value. `dest_addr` may equal either source.
- **Busy input:** `in_valid` during ALU or DIV is ignored; no queueing.
- **Arithmetic:** all unsigned, with no sign extension.

## Timing
- **Reset values:**
  - All registers are 0; state is IDLE.
  - `result` = 0, `out_valid` = 0, `flag_zero` = 1, `flag_carry` = 0, `flag_dz` = 0.
  - `in_ready` = 1 on the first cycle after `reset` deasserts.
- **Reset mid-operation:** the current operation is aborted. No write-back, no `out_valid`, and all registers are cleared.
- **Latency**, counted from the acceptance edge T:
  - ALU-class ops: completion edge T+1; `out_valid` during [T+1, T+2).
  - DIV/REM with nonzero divisor: completion edge T+DATA_W; `out_valid` during [T+DATA_W, T+DATA_W+1).
- **Throughput:** one ALU-class op every 2 cycles; one DIV/REM every DATA_W+1 cycles.
- **Debug port:** `rd_data` is combinational and reflects a write-back from the edge after it happens.

## Test plan
All scenarios use DATA_W=8, REG_N=4.
1. LDI r1=200, LDI r2=100, ADD r3=r1+r2 -> `result`=44, `flag_carry`=1, `out_valid` exactly one cycle after each completion edge, `rd_data`(r3)=44.
2. SUB r0=r2-r1 -> 156, `flag_carry`=1. Then SUB r0=r1-r2 -> 100, `flag_carry`=0. Then SUB r1-r1 -> 0, `flag_zero`=1.
3. LDI r1=16, LDI r2=17, MUL -> 16 (272 mod 256), `flag_carry`=1. Issue back-to-back with `in_valid` held high -> `in_ready` low exactly in ALU cycles, and one accept every 2 cycles.
4. r1=200, r2=7. DIV -> 28 and REM -> 4, each with `out_valid` 8 edges after acceptance. `in_valid` pulses during DIV are ignored, with no extra completions.
5. r0=0, r1=5. DIV r1/r0 -> 255, `flag_dz`=1, latency 1. REM -> 5, `flag_dz`=1. A following ADD clears `flag_dz` to 0.
6. Assert `reset` 3 cycles into a DIV -> no `out_valid`, all registers read 0, `in_ready`=0 while reset is high and =1 on the cycle after release. An ADD then returns 0 with `flag_zero`=1.

Source files
------------

// File: rtl/execute_pipe.sv
// Multi-cycle execute unit: register file, valid/ready issue, one-cycle ALU ops
// and an iterative restoring divider producing one quotient bit per cycle.
module execute_pipe #(
    parameter int DATA_W = 8,
    parameter int REG_N = 4,
    localparam int ADDR_W = $clog2(REG_N)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op_code,
    input  logic [ADDR_W-1:0] src_addr1,
    input  logic [ADDR_W-1:0] src_addr2,
    input  logic [ADDR_W-1:0] dest_addr,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] result,
    output logic              out_valid,
    output logic              flag_zero,
    output logic              flag_carry,
    output logic              flag_dz,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    localparam int CNT_W = $clog2(DATA_W);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_REM = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_LDI = 3'b111;

    typedef enum logic [1:0] {IDLE, ALU, DIV, DONE} state_t;

    state_t state, next_state;

    logic [DATA_W-1:0] regs [REG_N];
    logic [DATA_W-1:0] a_q, b_q, imm_q;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] dest_q;
    logic [DATA_W-1:0] quo_q, rem_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              accept, to_div, div_last;
    logic [DATA_W:0]   sum;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0] alu_r;
    logic              alu_c, alu_dz;
    logic [DATA_W:0]   rem_shift;
    logic              rem_ge;
    logic [DATA_W-1:0] rem_next, quo_next;
    logic              wb_en, wb_c, wb_dz;
    logic [DATA_W-1:0] wb_data;

    assign in_ready  = !reset && (state == IDLE || state == DONE);
    assign accept    = in_valid && in_ready;
    assign to_div    = (op_code == OP_DIV || op_code == OP_REM) && (regs[src_addr2] != '0);
    assign out_valid = (state == DONE);
    assign rd_data   = regs[rd_addr];
    assign div_last  = (cnt_q == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: begin
                if (accept)              next_state = to_div ? DIV : ALU;
                else if (state == DONE)  next_state = IDLE;
            end
            ALU:     next_state = DONE;
            DIV:     if (div_last) next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    // Only DIV/REM with a zero divisor reach the ALU, so those cases are the dz results
    always_comb begin
        alu_r  = '0;
        alu_c  = 1'b0;
        alu_dz = 1'b0;
        sum    = {1'b0, a_q} + {1'b0, b_q};
        prod   = {{DATA_W{1'b0}}, a_q} * {{DATA_W{1'b0}}, b_q};
        case (op_q)
            OP_ADD: begin alu_r = sum[DATA_W-1:0]; alu_c = sum[DATA_W]; end
            OP_SUB: begin alu_r = a_q - b_q; alu_c = (a_q < b_q); end
            OP_MUL: begin alu_r = prod[DATA_W-1:0]; alu_c = |prod[2*DATA_W-1:DATA_W]; end
            OP_DIV: begin alu_r = '1; alu_dz = 1'b1; end
            OP_REM: begin alu_r = a_q; alu_dz = 1'b1; end
            OP_AND: alu_r = a_q & b_q;
            OP_XOR: alu_r = a_q ^ b_q;
            OP_LDI: alu_r = imm_q;
            default: alu_r = '0;
        endcase
    end

    // Restoring step; the subtraction is exact modulo 2^DATA_W whenever it is taken
    always_comb begin
        rem_shift = {rem_q, quo_q[DATA_W-1]};
        rem_ge    = (rem_shift >= {1'b0, b_q});
        rem_next  = rem_ge ? (rem_shift[DATA_W-1:0] - b_q) : rem_shift[DATA_W-1:0];
        quo_next  = {quo_q[DATA_W-2:0], rem_ge};
    end

    always_comb begin
        wb_en   = 1'b0;
        wb_data = alu_r;
        wb_c    = alu_c;
        wb_dz   = alu_dz;
        if (state == ALU) begin
            wb_en = 1'b1;
        end else if (state == DIV && div_last) begin
            wb_en   = 1'b1;
            wb_data = (op_q == OP_DIV) ? quo_next : rem_next;
            wb_c    = 1'b0;
            wb_dz   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REG_N; i++) regs[i] <= '0;
            a_q        <= '0;
            b_q        <= '0;
            imm_q      <= '0;
            op_q       <= '0;
            dest_q     <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            result     <= '0;
            flag_zero  <= 1'b1;
            flag_carry <= 1'b0;
            flag_dz    <= 1'b0;
        end else begin
            if (accept) begin
                a_q    <= regs[src_addr1];
                b_q    <= regs[src_addr2];
                imm_q  <= imm;
                op_q   <= op_code;
                dest_q <= dest_addr;
                quo_q  <= regs[src_addr1];
                rem_q  <= '0;
                cnt_q  <= '0;
            end else if (state == DIV) begin
                quo_q <= quo_next;
                rem_q <= rem_next;
                cnt_q <= cnt_q + 1'b1;
            end
            if (wb_en) begin
                regs[dest_q] <= wb_data;
                result       <= wb_data;
                flag_zero    <= (wb_data == '0);
                flag_carry   <= wb_c;
                flag_dz      <= wb_dz;
            end
        end
    end
endmodule

// File: tb/tb_execute_pipe.sv
// Directed self-checking bench for execute_pipe with DATA_W=8, REG_N=4.
module tb_execute_pipe;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_REM = 3'b100;
    localparam logic [2:0] OP_LDI = 3'b111;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] op_code = '0;
    logic [1:0] src_addr1 = '0, src_addr2 = '0, dest_addr = '0, rd_addr = '0;
    logic [7:0] imm = '0;
    logic [7:0] result, rd_data;
    logic       out_valid, flag_zero, flag_carry, flag_dz;

    int checks = 0;
    int failures = 0;

    execute_pipe #(.DATA_W(8), .REG_N(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op_code(op_code), .src_addr1(src_addr1), .src_addr2(src_addr2),
        .dest_addr(dest_addr), .imm(imm), .result(result), .out_valid(out_valid),
        .flag_zero(flag_zero), .flag_carry(flag_carry), .flag_dz(flag_dz),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Issue one instruction, then count edges from acceptance until out_valid is seen
    task automatic applyStimulus(input string tag, input logic [2:0] op, input logic [1:0] s1,
                                 input logic [1:0] s2, input logic [1:0] d, input logic [7:0] im,
                                 input bit pulse, output int lat);
        bit done;
        @(negedge clk);
        op_code = op; src_addr1 = s1; src_addr2 = s2; dest_addr = d; imm = im;
        in_valid = 1'b1;
        checkOutput({tag, "_issue_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) done = 1'b1;
            else in_valid = pulse & lat[0];
        end
        in_valid = 1'b0;
    endtask

    task automatic runOp(input string tag, input logic [2:0] op, input logic [1:0] s1,
                         input logic [1:0] s2, input logic [1:0] d, input logic [7:0] im,
                         input logic [7:0] exp_r, input bit exp_c, input bit exp_dz,
                         input int exp_lat, input bit pulse);
        int lat;
        applyStimulus(tag, op, s1, s2, d, im, pulse, lat);
        checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        checkOutput({tag, "_result"}, 32'(result), 32'(exp_r));
        checkOutput({tag, "_carry"}, 32'(flag_carry), 32'(exp_c));
        checkOutput({tag, "_dz"}, 32'(flag_dz), 32'(exp_dz));
        checkOutput({tag, "_zero"}, 32'(flag_zero), 32'(exp_r == 8'd0));
        rd_addr = d;
        #1 checkOutput({tag, "_rd_data"}, 32'(rd_data), 32'(exp_r));
        @(negedge clk);
        checkOutput({tag, "_ov_one_cycle"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("rst_result", 32'(result), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_zero", 32'(flag_zero), 32'd1);
        checkOutput("rst_carry", 32'(flag_carry), 32'd0);
        checkOutput("rst_dz", 32'(flag_dz), 32'd0);
        checkOutput("rst_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            rd_addr = 2'(i);
            #1 checkOutput("rst_reg", 32'(rd_data), 32'd0);
        end

        // Scenario 1: add with carry
        runOp("ldi_r1", OP_LDI, 2'd0, 2'd0, 2'd1, 8'd200, 8'd200, 1'b0, 1'b0, 1, 1'b0);
        runOp("ldi_r2", OP_LDI, 2'd0, 2'd0, 2'd2, 8'd100, 8'd100, 1'b0, 1'b0, 1, 1'b0);
        runOp("add", OP_ADD, 2'd1, 2'd2, 2'd3, 8'd0, 8'd44, 1'b1, 1'b0, 1, 1'b0);

        // Scenario 2: subtract with and without borrow, then zero
        runOp("sub_borrow", OP_SUB, 2'd2, 2'd1, 2'd0, 8'd0, 8'd156, 1'b1, 1'b0, 1, 1'b0);
        runOp("sub_plain", OP_SUB, 2'd1, 2'd2, 2'd0, 8'd0, 8'd100, 1'b0, 1'b0, 1, 1'b0);
        runOp("sub_zero", OP_SUB, 2'd1, 2'd1, 2'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1, 1'b0);

        // Scenario 3: multiply overflow, then back-to-back accumulate r0 += r1
        runOp("ldi_16", OP_LDI, 2'd0, 2'd0, 2'd1, 8'd16, 8'd16, 1'b0, 1'b0, 1, 1'b0);
        runOp("ldi_17", OP_LDI, 2'd0, 2'd0, 2'd2, 8'd17, 8'd17, 1'b0, 1'b0, 1, 1'b0);
        runOp("mul", OP_MUL, 2'd1, 2'd2, 2'd3, 8'd0, 8'd16, 1'b1, 1'b0, 1, 1'b0);
        @(negedge clk);
        op_code = OP_ADD; src_addr1 = 2'd0; src_addr2 = 2'd1; dest_addr = 2'd0;
        in_valid = 1'b1;
        for (int i = 0; i <= 6; i++) begin
            checkOutput("b2b_ready", 32'(in_ready), 32'(i % 2 == 0));
            checkOutput("b2b_out_valid", 32'(out_valid), 32'(i % 2 == 0 && i > 0));
            if (i == 5) in_valid = 1'b0;
            if (i < 6) @(negedge clk);
        end
        checkOutput("b2b_result", 32'(result), 32'd48);
        rd_addr = 2'd0;
        #1 checkOutput("b2b_r0", 32'(rd_data), 32'd48);
        @(negedge clk);
        checkOutput("b2b_tail_ov", 32'(out_valid), 32'd0);

        // Scenario 4: division with ignored busy pulses
        runOp("ldi_200", OP_LDI, 2'd0, 2'd0, 2'd1, 8'd200, 8'd200, 1'b0, 1'b0, 1, 1'b0);
        runOp("ldi_7", OP_LDI, 2'd0, 2'd0, 2'd2, 8'd7, 8'd7, 1'b0, 1'b0, 1, 1'b0);
        runOp("div", OP_DIV, 2'd1, 2'd2, 2'd3, 8'd0, 8'd28, 1'b0, 1'b0, 8, 1'b1);
        runOp("rem", OP_REM, 2'd1, 2'd2, 2'd0, 8'd0, 8'd4, 1'b0, 1'b0, 8, 1'b1);

        // Scenario 5: divide by zero
        runOp("ldi_r0_0", OP_LDI, 2'd0, 2'd0, 2'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1, 1'b0);
        runOp("ldi_r1_5", OP_LDI, 2'd0, 2'd0, 2'd1, 8'd5, 8'd5, 1'b0, 1'b0, 1, 1'b0);
        runOp("div_dz", OP_DIV, 2'd1, 2'd0, 2'd2, 8'd0, 8'd255, 1'b0, 1'b1, 1, 1'b0);
        runOp("rem_dz", OP_REM, 2'd1, 2'd0, 2'd3, 8'd0, 8'd5, 1'b0, 1'b1, 1, 1'b0);
        runOp("add_clr_dz", OP_ADD, 2'd1, 2'd0, 2'd0, 8'd0, 8'd5, 1'b0, 1'b0, 1, 1'b0);

        // Scenario 6: reset three cycles into a division
        runOp("ldi_r1_200", OP_LDI, 2'd0, 2'd0, 2'd1, 8'd200, 8'd200, 1'b0, 1'b0, 1, 1'b0);
        runOp("ldi_r2_7", OP_LDI, 2'd0, 2'd0, 2'd2, 8'd7, 8'd7, 1'b0, 1'b0, 1, 1'b0);
        @(negedge clk);
        op_code = OP_DIV; src_addr1 = 2'd1; src_addr2 = 2'd2; dest_addr = 2'd3;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("abort_ready_hi", 32'(in_ready), 32'd0);
        checkOutput("abort_ov_hi", 32'(out_valid), 32'd0);
        @(negedge clk);
        checkOutput("abort_ready_idle", 32'(in_ready), 32'd0);
        checkOutput("abort_ov_idle", 32'(out_valid), 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("abort_ready_rel", 32'(in_ready), 32'd1);
        checkOutput("abort_result", 32'(result), 32'd0);
        checkOutput("abort_zero", 32'(flag_zero), 32'd1);
        for (int i = 0; i < 4; i++) begin
            rd_addr = 2'(i);
            #1 checkOutput("abort_reg", 32'(rd_data), 32'd0);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checkOutput("abort_no_ov", 32'(out_valid), 32'd0);
        end
        runOp("add_after_rst", OP_ADD, 2'd1, 2'd2, 2'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
